sram_wb_arbiter: RTL and testbench
==================================

# sram_wb_arbiter

Shares the single byte-wide SRAM access port (`sram_rw`) between the instruction and data Wishbone buses of the CPU. Each 32-bit Wishbone access becomes four sequential byte accesses. The block drives the `sram_rw` command inputs, reassembles read bytes into a word, and returns a single-cycle ack to the granted bus. Simultaneous requests are resolved round-robin.

## Interface
Parameters:
- `AW`, 14: SRAM byte-address width; word address is `adr[AW-1:2]`.

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `ibus_cyc_i` in 1: instruction bus request (read-only).
- `ibus_adr_i` in 32: instruction word address; bits `[AW-1:2]` used, rest ignored.
- `ibus_rdt_o` out 32: instruction read data.
- `ibus_ack_o` out 1: instruction ack, one-cycle pulse.
- `dbus_cyc_i` in 1: data bus request.
- `dbus_we_i` in 1: data write enable.
- `dbus_sel_i` in 4: write byte enables; ignored on reads.
- `dbus_adr_i` in 32: data word address; bits `[AW-1:2]` used.
- `dbus_dat_i` in 32: write data.
- `dbus_rdt_o` out 32: data read data.
- `dbus_ack_o` out 1: data ack, one-cycle pulse.
- `sram_read_o` out 1: to `sram_rw.read_i`.
- `sram_write_o` out 1: to `sram_rw.write_i`.
- `sram_addr_o` out AW: to `sram_rw.addr_i`.
- `sram_wdata_o` out 8: to `sram_rw.wdata_i`.
- `sram_rdata_i` in 8: from `sram_rw.rdata_o`; registered, valid the cycle after the read command.

## Operation
- Byte order is little-endian: byte n sits at SRAM address `{adr[AW-1:2], n[1:0]}` and maps to word bits `[8n+7:8n]`.
- States:
  - IDLE: no command. Any pending request moves the FSM to ACCESS.
  - ACCESS: 4 cycles, byte counter 0→3, one command per cycle.
  - DRAIN: one cycle, captures the last read byte.
  - ACK: one cycle, pulses ack, then returns to IDLE.
- Grant is decided in IDLE. On grant, the block latches port id, word address, we, sel and wdat. Port inputs are not sampled again until the next IDLE.
- Arbitration:
  - One request alone is granted.
  - If both request in the same IDLE cycle, the port not granted last wins.
  - The last-granted pointer resets to "dbus", so ibus wins the first tie.
- Reads (ibus, or dbus with we=0):
  - In ACCESS, `sram_read_o=1` with address byte = counter.
  - `sram_rdata_i` is captured into word lane (counter−1) in the following cycle: ACCESS cycles 2–4 capture lanes 0–2, DRAIN captures lane 3.
- Writes (dbus, we=1):
  - In ACCESS, `sram_write_o = sel[counter]` and `sram_wdata_o = dat[8·counter+7 : 8·counter]`.
  - Unselected bytes issue no command but still consume their cycle, so latency is fixed.
  - `sram_read_o` is never asserted during a write.
- The assembled word register drives both `*_rdt_o`; its contents are don't-care outside ACK and after writes.
- In ACK, only the granted port's ack is 1.
- `sram_read_o` and `sram_write_o` are never both 1, and both are 0 outside ACCESS.
- A requester dropping cyc mid-transaction is ignored; the access completes and ack still pulses.
- A requester holding cyc after its ack is treated as a new request in the next IDLE.

## Timing
- Grant in cycle t0 (IDLE); commands in t1–t4; DRAIN t5; ack at t6; IDLE at t7.
- Ack therefore comes 6 cycles after the first cycle cyc is seen in IDLE. Back-to-back throughput is one word per 7 cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from cyc to ack.
- Reset values: state IDLE, all acks 0, `sram_read_o`/`sram_write_o` 0, `sram_addr_o` 0, `sram_wdata_o` 0, rdt registers 0.
- Reset asserted mid-access: state returns to IDLE immediately and asynchronously, commands drop, no ack is issued, and the pointer resets. The requester must reissue.

## Structure
- Shared package `sram_pkg`:
  - state enum {IDLE, ACCESS, DRAIN, ACK};
  - `SRAM_AW = 14`, `BYTES_PER_WORD = 4`;
  - port-id constants `PORT_IBUS`, `PORT_DBUS`.
- Sub-module `sram_rr_arb2`: 2-requester round-robin arbiter.
  - Inputs: requests and an enable strobe.
  - Outputs: one-hot grant.
  - Holds the last-granted pointer; the pointer updates only on the enable strobe.
- The top-level netlist instantiates this block directly in front of `sram_rw`.

## Test plan
- ibus read at word 0x010 with SRAM bytes 0x40..0x43 = 11,22,33,44 → `sram_read_o` on addresses 0x040–0x043 in t1–t4; `ibus_rdt_o=0x44332211`, `ibus_ack_o` pulses at t6 only.
- dbus write at word 0x020, sel=0b0101, dat=0xAABBCCDD → writes DD@0x080 and BB@0x082 only, no command in the other two cycles; ack at t6. A following read returns the untouched bytes unchanged.
- ibus and dbus assert cyc in the same cycle after reset → ibus granted first, dbus second. Repeating the tie alternates grants.
- Continuous dbus cyc held for 3 accesses with ibus idle → acks at t6, t13, t20; no ibus ack.
- Reset pulsed during ACCESS byte 2 of a write → no further write strobes and no ack; after release the FSM is IDLE and a fresh read completes normally.
- Scoreboard across random traffic: never read and write together, never both acks, at most one ack per grant.

Source files
------------

// File: rtl/sram_pkg.sv
`timescale 1ns / 1ps
// Shared types and constants for the byte-wide SRAM Wishbone front end.
package sram_pkg;

   localparam int unsigned SRAM_AW        = 14;
   localparam int unsigned BYTES_PER_WORD = 4;

   // Requester identifiers, also used as grant-vector indices.
   localparam logic PORT_IBUS = 1'b0;
   localparam logic PORT_DBUS = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DRAIN,
      ACK
   } state_e;

   // Bit offset of byte lane n inside a 32-bit word.
   function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
`timescale 1ns / 1ps
// Two-requester round-robin arbiter with a last-granted pointer.
module sram_rr_arb2
   import sram_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic last_q;

   // A lone request wins outright; a tie goes to the port not granted last.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = (last_q == PORT_DBUS) ? 2'b01 : 2'b10;
      end
   end

   // Pointer follows the grant only when the owner accepts it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= PORT_DBUS;
      end else if (en_i && (|req_i)) begin
         last_q <= gnt_o[PORT_DBUS];
      end
   end

endmodule

// File: rtl/sram_wb_arbiter.sv
`timescale 1ns / 1ps
// Shares one byte-wide SRAM port between the instruction and data
// Wishbone buses; each word access is split into four byte commands.
module sram_wb_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned AW = SRAM_AW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          ibus_cyc_i,
   input  logic [31:0]   ibus_adr_i,
   output logic [31:0]   ibus_rdt_o,
   output logic          ibus_ack_o,
   input  logic          dbus_cyc_i,
   input  logic          dbus_we_i,
   input  logic [3:0]    dbus_sel_i,
   input  logic [31:0]   dbus_adr_i,
   input  logic [31:0]   dbus_dat_i,
   output logic [31:0]   dbus_rdt_o,
   output logic          dbus_ack_o,
   output logic          sram_read_o,
   output logic          sram_write_o,
   output logic [AW-1:0] sram_addr_o,
   output logic [7:0]    sram_wdata_o,
   input  logic [7:0]    sram_rdata_i
);

   state_e        state_q;
   logic [1:0]    cnt_q;
   logic [1:0]    cnt_d;
   logic          port_q;
   logic [AW-3:0] adr_q;
   logic          we_q;
   logic [3:0]    sel_q;
   logic [31:0]   dat_q;

   logic          read_q;
   logic          write_q;
   logic [AW-1:0] addr_q;
   logic [7:0]    wdata_q;
   logic [31:0]   word_q;
   logic          ibus_ack_q;
   logic          dbus_ack_q;

   logic [1:0]    req;
   logic [1:0]    gnt;
   logic          arb_en;
   logic          gnt_dbus;
   logic [AW-3:0] adr_d;
   logic          we_d;
   logic [3:0]    sel_d;
   logic [31:0]   dat_d;

   logic          unused_adr_bits;

   assign unused_adr_bits = ^{ibus_adr_i[31:AW], ibus_adr_i[1:0],
                              dbus_adr_i[31:AW], dbus_adr_i[1:0]};

   assign req    = {dbus_cyc_i, ibus_cyc_i};
   assign arb_en = (state_q == IDLE);

   sram_rr_arb2 u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (req),
      .en_i   (arb_en),
      .gnt_o  (gnt)
   );

   // Transaction parameters captured from whichever port wins in IDLE.
   always_comb begin
      gnt_dbus = gnt[PORT_DBUS];
      adr_d    = gnt_dbus ? dbus_adr_i[AW-1:2] : ibus_adr_i[AW-1:2];
      we_d     = gnt_dbus & dbus_we_i;
      sel_d    = gnt_dbus ? dbus_sel_i : 4'b0000;
      dat_d    = gnt_dbus ? dbus_dat_i : '0;
      cnt_d    = cnt_q + 2'd1;
   end

   // Access sequencer. Commands are registered one cycle ahead, so the
   // grant cycle already loads byte 0 and each ACCESS cycle loads the next.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         port_q     <= PORT_DBUS;
         adr_q      <= '0;
         we_q       <= 1'b0;
         sel_q      <= '0;
         dat_q      <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         ibus_ack_q <= 1'b0;
         dbus_ack_q <= 1'b0;
      end else begin
         ibus_ack_q <= 1'b0;
         dbus_ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (|gnt) begin
                  port_q  <= gnt_dbus;
                  adr_q   <= adr_d;
                  we_q    <= we_d;
                  sel_q   <= sel_d;
                  dat_q   <= dat_d;
                  cnt_q   <= '0;
                  read_q  <= ~we_d;
                  write_q <= we_d & sel_d[0];
                  addr_q  <= {adr_d, 2'b00};
                  wdata_q <= we_d ? dat_d[7:0] : '0;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               // Read data lags its command by one cycle.
               if (!we_q && (cnt_q != 2'd0)) begin
                  word_q[lane_lsb(cnt_q - 2'd1) +: 8] <= sram_rdata_i;
               end
               if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  wdata_q <= '0;
                  state_q <= DRAIN;
               end else begin
                  cnt_q   <= cnt_d;
                  read_q  <= ~we_q;
                  write_q <= we_q & sel_q[cnt_d];
                  addr_q  <= {adr_q, cnt_d};
                  wdata_q <= we_q ? dat_q[lane_lsb(cnt_d) +: 8] : '0;
               end
            end
            DRAIN: begin
               if (!we_q) begin
                  word_q[lane_lsb(2'd3) +: 8] <= sram_rdata_i;
               end
               ibus_ack_q <= (port_q == PORT_IBUS);
               dbus_ack_q <= (port_q == PORT_DBUS);
               state_q    <= ACK;
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sram_read_o  = read_q;
   assign sram_write_o = write_q;
   assign sram_addr_o  = addr_q;
   assign sram_wdata_o = wdata_q;
   assign ibus_rdt_o   = word_q;
   assign dbus_rdt_o   = word_q;
   assign ibus_ack_o   = ibus_ack_q;
   assign dbus_ack_o   = dbus_ack_q;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
`timescale 1ns / 1ps
// Directed and random bench for sram_wb_arbiter with a byte SRAM model.
module tb_sram_wb_arbiter;

   localparam int AW = 14;
   localparam int NB = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ibus_cyc = 1'b0;
   logic [31:0]   ibus_adr = '0;
   logic [31:0]   ibus_rdt;
   logic          ibus_ack;
   logic          dbus_cyc = 1'b0;
   logic          dbus_we = 1'b0;
   logic [3:0]    dbus_sel = '0;
   logic [31:0]   dbus_adr = '0;
   logic [31:0]   dbus_dat = '0;
   logic [31:0]   dbus_rdt;
   logic          dbus_ack;
   logic          sram_read;
   logic          sram_write;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_wdata;
   logic [7:0]    sram_rdata = '0;

   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [7:0]    pre_data = '0;

   logic [7:0] mem     [0:NB-1] = '{default: 8'h00};
   logic [7:0] ref_mem [0:NB-1] = '{default: 8'h00};

   typedef struct packed {
      logic        port;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
      int            cyc;
   } cmd_t;

   exp_t sb[$];
   cmd_t log_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc_cnt = 0;

   always #5 clk = ~clk;

   sram_wb_arbiter #(.AW(AW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ibus_cyc_i   (ibus_cyc),
      .ibus_adr_i   (ibus_adr),
      .ibus_rdt_o   (ibus_rdt),
      .ibus_ack_o   (ibus_ack),
      .dbus_cyc_i   (dbus_cyc),
      .dbus_we_i    (dbus_we),
      .dbus_sel_i   (dbus_sel),
      .dbus_adr_i   (dbus_adr),
      .dbus_dat_i   (dbus_dat),
      .dbus_rdt_o   (dbus_rdt),
      .dbus_ack_o   (dbus_ack),
      .sram_read_o  (sram_read),
      .sram_write_o (sram_write),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_rdata_i (sram_rdata)
   );

   // Byte SRAM with registered read data; pre_en is a bench-side backdoor.
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (sram_write) mem[sram_addr] <= sram_wdata;
      if (sram_read) sram_rdata <= mem[sram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Protocol monitor and scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("rw_exclusive", 32'(sram_read & sram_write), 32'd0);
         chk("ack_exclusive", 32'(ibus_ack & dbus_ack), 32'd0);
         if (sram_read || sram_write)
            log_q.push_back('{sram_write, sram_addr, sram_wdata, cyc_cnt});
         if (ibus_ack || dbus_ack) begin
            chk("ack_has_grant", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("ack_port", 32'(dbus_ack), 32'(e.port));
               if (e.chk_data) chk("rdata", e.port ? dbus_rdt : ibus_rdt, e.data);
            end
         end
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
      pre_en = 1'b1; pre_addr = a; pre_data = v;
      ref_mem[a] = v;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic push_read(input logic port, input logic [31:0] adr);
      logic [AW-1:0] b;
      b = {adr[AW-1:2], 2'b00};
      sb.push_back('{port, 1'b1, {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]}});
   endtask

   task automatic push_write(input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      logic [AW-1:0] b;
      b = {adr[AW-1:2], 2'b00};
      for (int i = 0; i < 4; i++) if (sel[i]) ref_mem[b + AW'(i)] = dat[8*i +: 8];
      sb.push_back('{1'b1, 1'b0, 32'h0});
   endtask

   task automatic xfer(input logic port, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat, input int exp_lat);
      int lat;
      logic got;
      lat = 0; got = 1'b0;
      if (port) begin
         dbus_cyc = 1'b1; dbus_we = we; dbus_sel = sel; dbus_adr = adr; dbus_dat = dat;
      end else begin
         ibus_cyc = 1'b1; ibus_adr = adr;
      end
      while (!got && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         got = port ? dbus_ack : ibus_ack;
      end
      if (port) dbus_cyc = 1'b0; else ibus_cyc = 1'b0;
      chk("ack_seen", 32'(got), 32'd1);
      chk("ack_latency", 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      chk("ack_one_cycle", 32'(port ? dbus_ack : ibus_ack), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k0;
      int nack;
      int ib;
      int ack_at[3];
      cmd_t c;
      logic [31:0] radr;
      logic [31:0] rdat;
      logic        rport;
      logic        rwe;
      logic [3:0]  rsel;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {28'h0, ibus_ack, dbus_ack, sram_read, sram_write}, 32'h0);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      chk("rst_wdata", 32'(sram_wdata), 32'h0);
      chk("rst_ibus_rdt", ibus_rdt, 32'h0);
      chk("rst_dbus_rdt", dbus_rdt, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Tie straight out of reset: ibus first, then dbus; repeated.
      for (int i = 0; i < 4; i++) begin
         preload(AW'(14'h100 + i), 8'(8'hA0 + i));
         preload(AW'(14'h200 + i), 8'(8'hB0 + i));
      end
      for (int r = 0; r < 2; r++) begin
         push_read(1'b0, 32'h100);
         push_read(1'b1, 32'h200);
         fork
            xfer(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 6);
            xfer(1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 13);
         join
      end

      // ibus read of word 0x010.
      preload(14'h040, 8'h11); preload(14'h041, 8'h22);
      preload(14'h042, 8'h33); preload(14'h043, 8'h44);
      log_q.delete();
      k0 = cyc_cnt;
      push_read(1'b0, 32'h40);
      xfer(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 6);
      chk("rd_cmd_count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         c = log_q[i];
         chk("rd_cmd_we", 32'(c.we), 32'd0);
         chk("rd_cmd_addr", 32'(c.addr), 32'(14'h040 + i));
         chk("rd_cmd_cycle", 32'(c.cyc - k0), 32'(i + 1));
      end

      // Partial dbus write to word 0x020.
      preload(14'h080, 8'h01); preload(14'h081, 8'h02);
      preload(14'h082, 8'h03); preload(14'h083, 8'h04);
      log_q.delete();
      k0 = cyc_cnt;
      push_write(4'b0101, 32'h80, 32'hAABBCCDD);
      xfer(1'b1, 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD, 6);
      chk("wr_cmd_count", 32'(log_q.size()), 32'd2);
      if (log_q.size() >= 2) begin
         c = log_q[0];
         chk("wr0_cmd", {c.we, 7'h0, 2'b00, c.addr, c.data}, {1'b1, 7'h0, 2'b00, 14'h080, 8'hDD});
         chk("wr0_cycle", 32'(c.cyc - k0), 32'd1);
         c = log_q[1];
         chk("wr2_cmd", {c.we, 7'h0, 2'b00, c.addr, c.data}, {1'b1, 7'h0, 2'b00, 14'h082, 8'hBB});
         chk("wr2_cycle", 32'(c.cyc - k0), 32'd3);
      end
      push_read(1'b1, 32'h80);
      xfer(1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 6);
      push_read(1'b0, 32'h80);
      xfer(1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 6);

      // dbus holds cyc across three back-to-back accesses.
      for (int i = 0; i < 3; i++) push_read(1'b1, 32'h40);
      ack_at = '{-1, -1, -1};
      nack = 0; ib = 0;
      dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_sel = 4'h0; dbus_adr = 32'h40;
      for (int n = 1; n <= 30 && nack < 3; n++) begin
         @(posedge clk); #1;
         if (ibus_ack) ib++;
         if (dbus_ack) begin ack_at[nack] = n; nack++; end
      end
      dbus_cyc = 1'b0;
      @(posedge clk); #1;
      chk("b2b_ack_count", 32'(nack), 32'd3);
      chk("b2b_ack0", 32'(ack_at[0]), 32'd6);
      chk("b2b_ack1", 32'(ack_at[1]), 32'd13);
      chk("b2b_ack2", 32'(ack_at[2]), 32'd20);
      chk("b2b_no_ibus_ack", 32'(ib), 32'd0);

      // Reset during byte 2 of a full write.
      preload(14'h0C0, 8'h00); preload(14'h0C1, 8'h00);
      preload(14'h0C2, 8'hEE); preload(14'h0C3, 8'hFF);
      log_q.delete();
      dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_sel = 4'hF;
      dbus_adr = 32'hC0; dbus_dat = 32'h55667788;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_byte2", {sram_write, 17'h0, sram_addr}, {1'b1, 17'h0, 14'h0C2});
      #1;
      rst_n = 1'b0;
      dbus_cyc = 1'b0;
      #1;
      chk("rst_mid_cmds", {30'h0, sram_read, sram_write}, 32'h0);
      chk("rst_mid_acks", {30'h0, ibus_ack, dbus_ack}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_write_count", 32'(log_q.size()), 32'd2);
      ref_mem[14'h0C0] = 8'h88;
      ref_mem[14'h0C1] = 8'h77;
      push_read(1'b1, 32'hC0);
      xfer(1'b1, 1'b0, 4'h0, 32'hC0, 32'h0, 6);

      // Fresh reset: pointer back to dbus, so ibus again wins the tie.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_read(1'b0, 32'h100);
      push_read(1'b1, 32'hC0);
      fork
         xfer(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 6);
         xfer(1'b1, 1'b0, 4'h0, 32'hC0, 32'h0, 13);
      join

      // Random single-requester traffic; upper address bits are noise.
      for (int t = 0; t < 24; t++) begin
         rport = 1'($urandom_range(0, 1));
         rwe   = rport & 1'($urandom_range(0, 1));
         rsel  = 4'($urandom_range(0, 15));
         rdat  = $urandom;
         radr  = {$urandom_range(0, 255), 24'h0} | 32'({$urandom_range(0, 15), 2'b00} << 2);
         if (rwe) push_write(rsel, radr, rdat);
         else push_read(rport, radr);
         xfer(rport, rwe, rsel, radr, rdat, 6);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
